op_sequencer: RTL and testbench

//   Sequences the compute engine from the op-code stream decoded by the serial

---
 rtl/op_sequencer.sv | 169 ++++++++++++++++
 tb/tb_op_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/op_sequencer.sv
// op_sequencer: queues op codes from the serial receiver, runs engine ops through a
// start/done handshake guarded by a watchdog, and returns one response code per op.
module op_sequencer #(
   parameter int unsigned OP_WIDTH       = 4,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic                op_valid_in,
   input  logic [OP_WIDTH-1:0] op_in,
   output logic                engine_start_out,
   output logic [OP_WIDTH-1:0] engine_op_out,
   input  logic                engine_done_in,
   output logic                resp_valid_out,
   output logic [OP_WIDTH-1:0] resp_data_out,
   input  logic                resp_ready_in,
   output logic                busy_out,
   output logic                overflow_out,
   output logic                timeout_out
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   localparam logic [OP_WIDTH-1:0] OP_NOP    = OP_WIDTH'(4'h0);
   localparam logic [OP_WIDTH-1:0] OP_ENG_LO = OP_WIDTH'(4'h1);
   localparam logic [OP_WIDTH-1:0] OP_ENG_HI = OP_WIDTH'(4'h4);
   localparam logic [OP_WIDTH-1:0] OP_CLEAR  = OP_WIDTH'(4'hF);
   localparam logic [OP_WIDTH-1:0] RESP_ERR  = OP_WIDTH'(4'hE);

   logic [1:0]          state_q,  state_d;
   logic [WD_W-1:0]     wd_q,     wd_d;
   logic [OP_WIDTH-1:0] eng_op_q, eng_op_d;
   logic [OP_WIDTH-1:0] resp_q,   resp_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    count_q,  count_d;
   logic                start_q,  start_d;
   logic                rvalid_q, rvalid_d;
   logic                busy_q,   busy_d;
   logic                ovf_q,    ovf_d;
   logic                to_q,     to_d;

   logic                push, pop, full, flag_clr, ovf_set, to_set;
   logic [OP_WIDTH-1:0] head;
   logic [OP_WIDTH-1:0] fifo_mem [FIFO_DEPTH];

   // Op storage is plain datapath; validity is tracked by the pointers and count.
   always_ff @(posedge clk_in) begin
      if (push) fifo_mem[wr_ptr_q] <= op_in;
   end

   // Next-state, FIFO bookkeeping and registered-output values.
   always_comb begin
      state_d  = state_q;
      wd_d     = wd_q;
      eng_op_d = eng_op_q;
      resp_d   = resp_q;
      pop      = 1'b0;
      flag_clr = 1'b0;
      to_set   = 1'b0;
      push     = 1'b0;
      ovf_set  = 1'b0;
      full     = (count_q == CNT_W'(FIFO_DEPTH));
      head     = fifo_mem[rd_ptr_q];

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop = 1'b1;
               if (head >= OP_ENG_LO && head <= OP_ENG_HI) begin
                  eng_op_d = head;
                  state_d  = S_ISSUE;
               end else if (head == OP_CLEAR) begin
                  resp_d   = OP_CLEAR;
                  flag_clr = 1'b1;
                  state_d  = S_RESP;
               end else if (head != OP_NOP) begin
                  resp_d  = RESP_ERR;
                  state_d = S_RESP;
               end
            end
         end
         S_ISSUE: begin
            wd_d    = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A done arriving on the expiry cycle still counts as a completion.
            if (engine_done_in) begin
               resp_d  = eng_op_q;
               state_d = S_RESP;
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               resp_d  = RESP_ERR;
               to_set  = 1'b1;
               state_d = S_RESP;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         S_RESP: begin
            if (resp_ready_in) begin
               eng_op_d = '0;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      push     = op_valid_in && (!full || pop);
      ovf_set  = op_valid_in && full && !pop;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

      // Set events override a same-cycle CLEAR.
      ovf_d    = (ovf_q && !flag_clr) || ovf_set;
      to_d     = (to_q  && !flag_clr) || to_set;
      start_d  = (state_d == S_ISSUE);
      rvalid_d = (state_d == S_RESP);
      busy_d   = (state_d != S_IDLE) || (count_d != '0);
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q  <= S_IDLE;
         wd_q     <= '0;
         eng_op_q <= '0;
         resp_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         start_q  <= 1'b0;
         rvalid_q <= 1'b0;
         busy_q   <= 1'b0;
         ovf_q    <= 1'b0;
         to_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         wd_q     <= wd_d;
         eng_op_q <= eng_op_d;
         resp_q   <= resp_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         start_q  <= start_d;
         rvalid_q <= rvalid_d;
         busy_q   <= busy_d;
         ovf_q    <= ovf_d;
         to_q     <= to_d;
      end
   end

   assign engine_start_out = start_q;
   assign engine_op_out    = eng_op_q;
   assign resp_valid_out   = rvalid_q;
   assign resp_data_out    = resp_q;
   assign busy_out         = busy_q;
   assign overflow_out     = ovf_q;
   assign timeout_out      = to_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Bench for op_sequencer: directed op streams; expected start ops and responses are
// queued at stimulus time and checked by an independent monitor.
module tb_op_sequencer;

   localparam int unsigned OP_W = 4;
   localparam int unsigned TMO  = 8;

   logic            clk_in = 1'b0;
   logic            rst_in;
   logic            op_valid_in;
   logic [OP_W-1:0] op_in;
   logic            engine_start_out;
   logic [OP_W-1:0] engine_op_out;
   logic            engine_done_in;
   logic            resp_valid_out;
   logic [OP_W-1:0] resp_data_out;
   logic            resp_ready_in;
   logic            busy_out;
   logic            overflow_out;
   logic            timeout_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [OP_W-1:0] exp_start_q [$];
   logic [OP_W-1:0] exp_resp_q  [$];
   logic [OP_W-1:0] burst [6];

   op_sequencer #(
      .OP_WIDTH      (OP_W),
      .FIFO_DEPTH    (4),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .op_valid_in     (op_valid_in),
      .op_in           (op_in),
      .engine_start_out(engine_start_out),
      .engine_op_out   (engine_op_out),
      .engine_done_in  (engine_done_in),
      .resp_valid_out  (resp_valid_out),
      .resp_data_out   (resp_data_out),
      .resp_ready_in   (resp_ready_in),
      .busy_out        (busy_out),
      .overflow_out    (overflow_out),
      .timeout_out     (timeout_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic tally(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_b(input string name, input logic act, input logic exp);
      tally(name, 32'(act), 32'(exp));
   endtask

   task automatic check_op(input string name, input logic [OP_W-1:0] act,
                           input logic [OP_W-1:0] exp);
      tally(name, 32'(act), 32'(exp));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic send_op(input logic [OP_W-1:0] op);
      op_valid_in = 1'b1;
      op_in       = op;
      step(1);
      op_valid_in = 1'b0;
      op_in       = '0;
   endtask

   task automatic wait_start(input string name);
      int k = 0;
      while (!engine_start_out && k < 50) begin
         step(1);
         k++;
      end
      check_b({name, "_start_seen"}, engine_start_out, 1'b1);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (busy_out && k < 300) begin
         step(1);
         k++;
      end
      check_b({name, "_idle"}, busy_out, 1'b0);
   endtask

   task automatic done_pulse();
      engine_done_in = 1'b1;
      step(1);
      engine_done_in = 1'b0;
   endtask

   // Monitor: every start pulse and every response transfer is matched against the queues.
   always @(negedge clk_in) begin
      if (rst_in === 1'b1) begin
         if (engine_start_out) begin
            if (exp_start_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_start: op 0x%0h, none expected", engine_op_out);
            end else begin
               check_op("start_op", engine_op_out, exp_start_q.pop_front());
            end
         end
         if (resp_valid_out && resp_ready_in) begin
            if (exp_resp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_resp: data 0x%0h, none expected", resp_data_out);
            end else begin
               check_op("resp_data", resp_data_out, exp_resp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      burst = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h1, 4'h2};
      rst_in         = 1'b0;
      op_valid_in    = 1'b0;
      op_in          = '0;
      engine_done_in = 1'b0;
      resp_ready_in  = 1'b1;
      #12;
      check_b ("rst_start",   engine_start_out, 1'b0);
      check_op("rst_eop",     engine_op_out,    4'h0);
      check_b ("rst_rvalid",  resp_valid_out,   1'b0);
      check_op("rst_rdata",   resp_data_out,    4'h0);
      check_b ("rst_busy",    busy_out,         1'b0);
      check_b ("rst_ovf",     overflow_out,     1'b0);
      check_b ("rst_tmo",     timeout_out,      1'b0);
      @(negedge clk_in);
      rst_in = 1'b1;
      step(2);

      // Single RUN with done five cycles after start.
      exp_start_q.push_back(4'h3);
      exp_resp_q.push_back(4'h3);
      send_op(4'h3);
      check_b ("t1_busy",        busy_out,         1'b1);
      check_b ("t1_no_early",    engine_start_out, 1'b0);
      step(1);
      check_b ("t1_start",       engine_start_out, 1'b1);
      check_op("t1_eop",         engine_op_out,    4'h3);
      step(4);
      check_op("t1_eop_stable",  engine_op_out,    4'h3);
      check_b ("t1_start_once",  engine_start_out, 1'b0);
      check_b ("t1_no_resp",     resp_valid_out,   1'b0);
      step(1);
      done_pulse();
      check_b ("t1_rvalid",      resp_valid_out,   1'b1);
      check_op("t1_rdata",       resp_data_out,    4'h3);
      step(1);
      check_b ("t1_rvalid_drop", resp_valid_out,   1'b0);
      check_b ("t1_busy_end",    busy_out,         1'b0);
      check_op("t1_eop_clr",     engine_op_out,    4'h0);

      // Burst with no done: first op pops before the burst ends, so the sixth overflows.
      for (int i = 0; i < 5; i++) begin
         exp_start_q.push_back(burst[i]);
         exp_resp_q.push_back(4'hE);
      end
      for (int i = 0; i < 6; i++) send_op(burst[i]);
      check_b ("t2_ovf",      overflow_out,   1'b1);
      check_b ("t2_tmo_pre",  timeout_out,    1'b0);
      step(5);
      check_b ("t2_rvalid",   resp_valid_out, 1'b1);
      check_op("t2_rdata",    resp_data_out,  4'hE);
      check_b ("t2_tmo",      timeout_out,    1'b1);
      wait_idle("t2");

      // CLEAR with both flags set.
      exp_resp_q.push_back(4'hF);
      send_op(4'hF);
      check_b ("t6_ovf_pre",  overflow_out,   1'b1);
      check_b ("t6_tmo_pre",  timeout_out,    1'b1);
      step(1);
      check_b ("t6_ovf_clr",  overflow_out,   1'b0);
      check_b ("t6_tmo_clr",  timeout_out,    1'b0);
      check_b ("t6_rvalid",   resp_valid_out, 1'b1);
      check_op("t6_rdata",    resp_data_out,  4'hF);
      wait_idle("t6");

      // Illegal, NOP, then LOAD_IN.
      exp_resp_q.push_back(4'hE);
      exp_start_q.push_back(4'h2);
      exp_resp_q.push_back(4'h2);
      send_op(4'h7);
      send_op(4'h0);
      send_op(4'h2);
      wait_start("t3");
      step(1);
      done_pulse();
      check_b ("t3_rvalid",   resp_valid_out, 1'b1);
      check_op("t3_rdata",    resp_data_out,  4'h2);
      wait_idle("t3");

      // Response back-pressure while more ops enqueue.
      exp_start_q.push_back(4'h4);
      exp_resp_q.push_back(4'h4);
      exp_start_q.push_back(4'h3);
      exp_resp_q.push_back(4'h3);
      send_op(4'h4);
      wait_start("t4");
      step(1);
      resp_ready_in = 1'b0;
      done_pulse();
      for (int i = 0; i < 10; i++) begin
         op_valid_in = (i < 2);
         op_in       = (i == 0) ? 4'h3 : 4'h0;
         check_b ("t4_hold_valid", resp_valid_out,   1'b1);
         check_op("t4_hold_data",  resp_data_out,    4'h4);
         check_b ("t4_no_start",   engine_start_out, 1'b0);
         step(1);
      end
      op_valid_in   = 1'b0;
      op_in         = '0;
      resp_ready_in = 1'b1;
      step(1);
      check_b ("t4_rvalid_drop", resp_valid_out, 1'b0);
      wait_start("t4b");
      step(1);
      done_pulse();
      wait_idle("t4");

      // Asynchronous reset in WAIT with a queued op; late done afterwards.
      exp_start_q.push_back(4'h1);
      send_op(4'h1);
      wait_start("t5");
      step(2);
      send_op(4'h2);
      #2 rst_in = 1'b0;
      #1;
      check_b ("t5_start",   engine_start_out, 1'b0);
      check_op("t5_eop",     engine_op_out,    4'h0);
      check_b ("t5_rvalid",  resp_valid_out,   1'b0);
      check_b ("t5_busy",    busy_out,         1'b0);
      check_b ("t5_ovf",     overflow_out,     1'b0);
      check_b ("t5_tmo",     timeout_out,      1'b0);
      @(negedge clk_in);
      rst_in = 1'b1;
      step(1);
      done_pulse();
      check_b ("t5_busy_after", busy_out,       1'b0);
      step(3);
      check_b ("t5_no_resp",    resp_valid_out, 1'b0);
      check_b ("t5_still_idle", busy_out,       1'b0);

      tally("start_queue_drained", 32'(exp_start_q.size()), 32'd0);
      tally("resp_queue_drained",  32'(exp_resp_q.size()),  32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
